sda_seq_driver: RTL
===================

# sda_seq_driver

Parametrised, sequential successor to the I2C SDA output select. Instead of statically muxing idle/start/stop/data levels, the block accepts bus-level commands (START, STOP, byte transmit, ACK, NACK, release), tracks SCL edges internally, and changes SDA a programmable number of clocks after each SCL event to meet hold time. It sits between the I2C controller FSM and the open-drain pad driver.

## Interface
- DATA_WIDTH, 8: bits shifted per TX command.
- HOLD_CYCLES, 2: clocks of SDA hold after the qualifying SCL event (0 allowed).
- MSB_FIRST, 1: 1 = transmit tx_data MSB first; 0 = LSB first.

- clk  in  1  system clock; all logic on rising edge.
- n_rst  in  1  synchronous, active-low reset.
- scl_in  in  1  synchronised SCL level.
- cmd_valid  in  1  command request.
- cmd  in  3  000 RELEASE, 001 START, 010 STOP, 011 TX, 100 ACK, 101 NACK, 110/111 illegal.
- tx_data  in  DATA_WIDTH  byte for TX; captured on accept.
- cmd_ready  out  1  high only in IDLE state.
- sda_out  out  1  SDA level to pad driver (1 = released).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at command completion.
- cmd_err  out  1  one-cycle pulse on illegal command.

## Operation
- Accept = cmd_valid & cmd_ready at a clock edge; cmd and tx_data latched; busy rises next cycle.
- scl_q = scl_in registered each cycle. Fall detected in cycle F when scl_q=1 and scl_in=0. High detected in any cycle with scl_in=1 (level).
- Edges are evaluated only in wait states, so an edge present in the accept cycle is ignored.
- HOLD state: counter loads HOLD_CYCLES on detection and decrements; when it reaches 0 the pending SDA value is registered. The new sda_out is visible in cycle E+HOLD_CYCLES+1, where E is the detection cycle.
- States: IDLE, WAIT_FALL, WAIT_HIGH, HOLD, DONE_PULSE (folded into the last HOLD exit).
- RELEASE: sda_out=1 and done in the cycle after accept; no SCL dependence.
- START: WAIT_HIGH, then HOLD, then sda_out=0 with done.
- STOP: WAIT_FALL, then HOLD, then sda_out=0. Next WAIT_HIGH, then HOLD, then sda_out=1 with done.
- TX: per bit, WAIT_FALL, then HOLD, then drive the next bit. Bit order follows MSB_FIRST; the bit counter runs 0..DATA_WIDTH-1. After the last bit, one more WAIT_FALL and HOLD, then sda_out=1 (released for slave ACK) with done.
- ACK/NACK: WAIT_FALL, then HOLD, then drive 0 (ACK) or 1 (NACK). Next WAIT_FALL, then HOLD, then sda_out=1 with done.
- Illegal: sda_out=1 and cmd_err pulse the cycle after accept; no done; return to IDLE.
- done and cmd_err never assert together. done is visible in the same cycle as the final sda_out value, and the block is back in IDLE (cmd_ready=1) that cycle.
- sda_out holds its last value in IDLE.

## Timing
- Reset (n_rst=0 at a clock edge): state IDLE, sda_out=1, cmd_ready=1, busy=0, done=0, cmd_err=0, counters=0, scl_q=1.
- Reset mid-command aborts it: sda_out=1 the next cycle, no done pulse.
- Back-to-back: a new command may be accepted in the done cycle. Its edge waiting starts the following cycle.
- SCL falling again while in HOLD is ignored; the counter completes.
- Minimum TX duration: (DATA_WIDTH+1) SCL falls.
- Hold counter width is $clog2(HOLD_CYCLES+1), with a minimum of 1 bit.

## Test plan
- Reset: hold n_rst=0 for 2 cycles with random inputs. Expect sda_out=1, cmd_ready=1, busy=0, done=0, cmd_err=0.
- START with HOLD_CYCLES=2 and scl_in already high: accept at cycle 0. Expect sda_out 1→0 and done visible at cycle 4 (first wait cycle 1 + 2 + 1), then cmd_ready=1.
- TX 0xA5, MSB_FIRST=1, SCL period 20 clocks: expect sda_out sequence 1,0,1,0,0,1,0,1, each change 3 cycles after its fall cycle. On the 9th fall+3, expect sda_out=1 and done. Repeat with MSB_FIRST=0 and expect 1,0,1,0,0,1,0,1 reversed (0xA5 LSB first = 1,0,1,0,0,1,0,1).
- ACK then STOP back-to-back: expect 0 after fall+3, then release 1 with done. STOP accepted in the done cycle gives 0 after the next fall+3, then 1 at high+3 with done.
- Illegal cmd 3'b110: expect cmd_err pulse for exactly 1 cycle, done=0, sda_out=1, cmd_ready=1 the next cycle.
- Reset mid-TX after 3 bits of 0x3C: expect sda_out=1 and busy=0 the next cycle, and no done. A following START must complete normally.

Source files
------------

// File: rtl/sda_seq_driver.sv
// -----------------------------------------------------------------------------
// sda_seq_driver
//
// Sequential I2C SDA driver. Accepts bus-level commands from the I2C controller
// FSM (RELEASE, START, STOP, byte TX, ACK, NACK), watches SCL, and moves SDA a
// programmable number of clocks after each qualifying SCL event so the pad
// sees the required data hold time. Feeds the open-drain pad driver.
//
// Parameters
//   DATA_WIDTH  : bits shifted per TX command
//   HOLD_CYCLES : clocks of SDA hold after the qualifying SCL event (0 allowed)
//   MSB_FIRST   : 1 = transmit MSB first, 0 = LSB first
//
// Ports
//   i_clk        in   system clock, rising edge
//   i_n_rst      in   synchronous active-low reset
//   i_scl_in     in   synchronised SCL level
//   i_cmd_valid  in   command request
//   i_cmd        in   000 RELEASE, 001 START, 010 STOP, 011 TX, 100 ACK,
//                     101 NACK, 110/111 illegal
//   i_tx_data    in   TX byte, captured on accept
//   o_cmd_ready  out  high only while idle
//   o_sda_out    out  SDA level to pad driver (1 = released)
//   o_busy       out  high whenever a command is in progress
//   o_done       out  one-cycle pulse at command completion
//   o_cmd_err    out  one-cycle pulse on an illegal command
// -----------------------------------------------------------------------------
module sda_seq_driver #(
    parameter int DATA_WIDTH  = 8,
    parameter int HOLD_CYCLES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_n_rst,
    input  logic                  i_scl_in,
    input  logic                  i_cmd_valid,
    input  logic [2:0]            i_cmd,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    output logic                  o_cmd_ready,
    output logic                  o_sda_out,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_cmd_err
);

    localparam int CNT_W  = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam int STEP_W = (DATA_WIDTH < 1) ? 1 : $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DATA_WIDTH);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};

    localparam logic [2:0] CMD_RELEASE = 3'b000;
    localparam logic [2:0] CMD_START   = 3'b001;
    localparam logic [2:0] CMD_STOP    = 3'b010;
    localparam logic [2:0] CMD_TX      = 3'b011;
    localparam logic [2:0] CMD_ACK     = 3'b100;
    localparam logic [2:0] CMD_NACK    = 3'b101;

    // The done pulse is produced on the final HOLD exit, so no separate state.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_FALL = 2'b01,
        ST_WAIT_HIGH = 2'b10,
        ST_HOLD      = 2'b11
    } state_t;

    // Per-step decode: {sda value, command complete, next step waits for SCL high}.
    // A step that does not complete always leads to another wait state.
    function automatic logic [2:0] step_decode(
        input logic [2:0]        cmd,
        input logic [STEP_W-1:0] step,
        input logic              data_bit
    );
        logic [2:0] res;
        case (cmd)
            CMD_START: res = 3'b010;
            CMD_STOP:  res = (step == STEP_ZERO) ? 3'b001 : 3'b110;
            CMD_TX:    res = (step == STEP_LAST) ? 3'b110 : {data_bit, 2'b00};
            CMD_ACK:   res = (step == STEP_ZERO) ? 3'b000 : 3'b110;
            CMD_NACK:  res = (step == STEP_ZERO) ? 3'b100 : 3'b110;
            default:   res = 3'b110;
        endcase
        return res;
    endfunction

    state_t                r_state, w_state;
    logic [2:0]            r_cmd, w_cmd;
    logic [DATA_WIDTH-1:0] r_shift, w_shift;
    logic [STEP_W-1:0]     r_step, w_step;
    logic [CNT_W-1:0]      r_cnt, w_cnt;
    logic                  r_sda, w_sda;
    logic                  r_done, w_done;
    logic                  r_err, w_err;
    logic                  r_scl_q;

    logic                  w_fall;
    logic                  w_detect;
    logic                  w_apply;
    logic                  w_data_bit;
    logic [2:0]            w_dec;

    assign w_fall     = r_scl_q & ~i_scl_in;
    assign w_data_bit = MSB_FIRST ? r_shift[DATA_WIDTH-1] : r_shift[0];
    assign w_dec      = step_decode(r_cmd, r_step, w_data_bit);

    // Edges only count in the wait states, so an edge in the accept cycle is ignored.
    assign w_detect = ((r_state == ST_WAIT_FALL) & w_fall) |
                      ((r_state == ST_WAIT_HIGH) & i_scl_in);

    // Commit the pending SDA value on the last hold cycle, or directly on the
    // detection when no hold is configured. Extra SCL edges during HOLD are ignored.
    assign w_apply = (w_detect & (HOLD_CYCLES == 0)) |
                     ((r_state == ST_HOLD) & (r_cnt <= CNT_ONE));

    // Next-state and next-datapath logic.
    always_comb begin
        w_state = r_state;
        w_cmd   = r_cmd;
        w_shift = r_shift;
        w_step  = r_step;
        w_cnt   = r_cnt;
        w_sda   = r_sda;
        w_done  = 1'b0;
        w_err   = 1'b0;
        if (w_apply) begin
            w_sda   = w_dec[2];
            w_step  = r_step + STEP_ONE;
            w_cnt   = CNT_ZERO;
            w_shift = MSB_FIRST ? (r_shift << 1'b1) : (r_shift >> 1'b1);
            if (w_dec[1]) begin
                w_state = ST_IDLE;
                w_done  = 1'b1;
            end else if (w_dec[0]) begin
                w_state = ST_WAIT_HIGH;
            end else begin
                w_state = ST_WAIT_FALL;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        w_cmd   = i_cmd;
                        w_shift = i_tx_data;
                        w_step  = STEP_ZERO;
                        w_cnt   = CNT_ZERO;
                        case (i_cmd)
                            CMD_RELEASE: begin
                                w_sda  = 1'b1;
                                w_done = 1'b1;
                            end
                            CMD_START:                           w_state = ST_WAIT_HIGH;
                            CMD_STOP, CMD_TX, CMD_ACK, CMD_NACK: w_state = ST_WAIT_FALL;
                            default: begin
                                w_sda = 1'b1;
                                w_err = 1'b1;
                            end
                        endcase
                    end else begin
                        w_state = ST_IDLE;
                    end
                end
                ST_WAIT_FALL, ST_WAIT_HIGH: begin
                    if (w_detect) begin
                        w_state = ST_HOLD;
                        w_cnt   = HOLD_LOAD;
                    end else begin
                        w_state = r_state;
                    end
                end
                ST_HOLD: begin
                    w_cnt = r_cnt - CNT_ONE;
                end
                default: begin
                    w_state = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_n_rst) begin
            r_state <= ST_IDLE;
            r_cmd   <= 3'b000;
            r_shift <= {DATA_WIDTH{1'b0}};
            r_step  <= STEP_ZERO;
            r_cnt   <= CNT_ZERO;
            r_sda   <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_scl_q <= 1'b1;
        end else begin
            r_state <= w_state;
            r_cmd   <= w_cmd;
            r_shift <= w_shift;
            r_step  <= w_step;
            r_cnt   <= w_cnt;
            r_sda   <= w_sda;
            r_done  <= w_done;
            r_err   <= w_err;
            r_scl_q <= i_scl_in;
        end
    end

    assign o_sda_out   = r_sda;
    assign o_done      = r_done;
    assign o_cmd_err   = r_err;
    assign o_cmd_ready = (r_state == ST_IDLE);
    assign o_busy      = (r_state != ST_IDLE);

endmodule
